// File: rtl/uart_pkg.sv
// Shared UART constants, level-width helper and FIFO operation encoding.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

    function automatic int uart_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int UART_TX_LVL_W = uart_lvl_w(UART_TX_FIFO_DEPTH);

    // Per-cycle buffer operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/dff.sv
// Generic D flop with asynchronous active-low reset to a parameterised value.
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit holding buffer feeding the TSR; DEPTH-entry FIFO when UART_TX_FIFO_EN
// is defined, otherwise a single 16450-style holding register with the same ports.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   thr_wr,
    input  logic [DATA_W-1:0]      thr_wdata,
    input  logic                   fifo_clr,
    input  logic                   tsr_load,
    input  logic                   tsr_idle,
    input  logic                   ovr_clr,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   thre,
    output logic                   temt,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic                   tx_ovr
);

    localparam int LVL_W = uart_lvl_w(DEPTH);

    logic             thre_w;
    logic             full_w;
    logic             push;
    logic             pop;
    logic             mem_we;
    fifo_op_e         op;
    logic [LVL_W-1:0] level_d;
    logic [LVL_W-1:0] level_q;
    logic [DATA_W-1:0] head_data;
    logic             tx_ovr_d;
    logic             tx_ovr_q;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;

    always_comb begin
        thre_w   = (level_q == '0);
        full_w   = (level_q == LVL_W'(DEPTH));
        // A write into a full buffer still lands when the TSR frees a slot this cycle.
        push     = thr_wr & (~full_w | tsr_load);
        pop      = tsr_load & ~thre_w;
        op       = fifo_op_e'({push, pop});
        mem_we   = push & ~fifo_clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case (op)
                OP_PUSH: level_d = level_q + LVL_W'(1);
                OP_POP:  level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    dff #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_wr_ptr (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (wr_ptr_d),
        .q     (wr_ptr_q)
    );

    dff #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_rd_ptr (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (rd_ptr_d),
        .q     (rd_ptr_q)
    );

    uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk   (pclk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (thr_wdata),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );
`else
    always_comb begin
        thre_w  = ~level_q[0];
        full_w  = level_q[0];
        push    = thr_wr & (~full_w | tsr_load);
        pop     = tsr_load & ~thre_w;
        op      = fifo_op_e'({push, pop});
        mem_we  = push & ~fifo_clr;
        level_d = level_q;
        // Only bit 0 ever carries occupancy; the upper level bits stay zero.
        if (fifo_clr) begin
            level_d = '0;
        end else begin
            case (op)
                OP_PUSH, OP_BOTH: level_d = LVL_W'(1);
                OP_POP:           level_d = '0;
                default:          level_d = level_q;
            endcase
        end
    end

    uart_fifo_mem #(.DEPTH(1), .DATA_W(DATA_W)) u_mem (
        .clk   (pclk),
        .we    (mem_we),
        .waddr (1'b0),
        .wdata (thr_wdata),
        .raddr (1'b0),
        .rdata (head_data)
    );
`endif

    dff #(.WIDTH(LVL_W), .RESET_VALUE('0)) u_level (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (level_d),
        .q     (level_q)
    );

    // Set wins over a same-cycle LSR-read clear; a flush leaves the flag alone.
    always_comb begin
        tx_ovr_d = (thr_wr & full_w & ~tsr_load) | (tx_ovr_q & ~ovr_clr);
    end

    dff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_ovr (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (tx_ovr_d),
        .q     (tx_ovr_q)
    );

    // Storage is never reset, so the head is masked while empty.
    assign tx_data  = thre_w ? '0 : head_data;
    assign thre     = thre_w;
    assign temt     = thre_w & tsr_idle;
    assign tx_full  = full_w;
    assign tx_level = level_q;
    assign tx_ovr   = tx_ovr_q;

    a_no_pop_when_empty: assert property (
        @(posedge pclk) disable iff (!presetn) tsr_load |-> !thre_w
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int LW = $clog2(16) + 1;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH_M = 16;
`else
  localparam int DEPTH_M = 1;
`endif
  localparam int L5 = (DEPTH_M < 5) ? DEPTH_M : 5;
  localparam int L3 = (DEPTH_M < 3) ? DEPTH_M : 3;

  logic          pclk      = 1'b0;
  logic          presetn   = 1'b1;
  logic          thr_wr    = 1'b0;
  logic [DW-1:0] thr_wdata = '0;
  logic          fifo_clr  = 1'b0;
  logic          tsr_load  = 1'b0;
  logic          tsr_idle  = 1'b1;
  logic          ovr_clr   = 1'b0;
  logic [DW-1:0] tx_data;
  logic          thre;
  logic          temt;
  logic          tx_full;
  logic [LW-1:0] tx_level;
  logic          tx_ovr;

  always #5 pclk = ~pclk;

  uart_tx_fifo dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .thr_wr    (thr_wr),
    .thr_wdata (thr_wdata),
    .fifo_clr  (fifo_clr),
    .tsr_load  (tsr_load),
    .tsr_idle  (tsr_idle),
    .ovr_clr   (ovr_clr),
    .tx_data   (tx_data),
    .thre      (thre),
    .temt      (temt),
    .tx_full   (tx_full),
    .tx_level  (tx_level),
    .tx_ovr    (tx_ovr)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // reference model: queue of bytes held, plus the sticky overrun flag
  logic [DW-1:0] exp_q[$];
  bit m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      exp_q.delete();
      m_ovr = 1'b0;
    end else begin
      bit full_now;
      full_now = (exp_q.size() == DEPTH_M);
      if (fifo_clr) begin
        exp_q.delete();
      end else begin
        if (tsr_load && exp_q.size() > 0) void'(exp_q.pop_front());
        if (thr_wr && (!full_now || tsr_load)) exp_q.push_back(thr_wdata);
      end
      m_ovr = (thr_wr && full_now && !tsr_load) || (m_ovr && !ovr_clr);
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("m_thre", thre, exp_q.size() == 0);
      check("m_temt", temt, (exp_q.size() == 0) && tsr_idle);
      check("m_full", tx_full, exp_q.size() == DEPTH_M);
      check("m_level", tx_level, exp_q.size());
      check("m_ovr", tx_ovr, m_ovr);
      check("m_data", tx_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    end
  end

  // called at posedge+1; applies inputs for exactly one clock edge
  task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit clr, input bit ld, input bit oc);
    thr_wr = wr; thr_wdata = d; fifo_clr = clr; tsr_load = ld; ovr_clr = oc;
    @(posedge pclk); #1;
    thr_wr = 1'b0; fifo_clr = 1'b0; tsr_load = 1'b0; ovr_clr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] e;
    #1 presetn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_thre", thre, 1);
    check("rst_full", tx_full, 0);
    check("rst_level", tx_level, 0);
    check("rst_ovr", tx_ovr, 0);
    check("rst_data", tx_data, 0);
    check("rst_temt_hi", temt, 1);
    tsr_idle = 1'b0; #1;
    check("rst_temt_lo", temt, 0);
    tsr_idle = 1'b1;
    @(posedge pclk); #2 presetn = 1'b1;
    @(posedge pclk); #1;

    // single byte in and out
    cyc(1, 8'hA5, 0, 0, 0);
    check("a5_thre", thre, 0);
    check("a5_level", tx_level, 1);
    check("a5_data", tx_data, 8'hA5);
    cyc(0, 0, 0, 1, 0);
    check("a5_pop_thre", thre, 1);
    check("a5_pop_data", tx_data, 0);

    // fill, overrun, drain in order
    for (int i = 0; i < DEPTH_M; i++) cyc(1, DW'(i), 0, 0, 0);
    check("fill_full", tx_full, 1);
    check("fill_level", tx_level, DEPTH_M);
    cyc(1, 8'hFF, 0, 0, 0);
    check("ovr_set", tx_ovr, 1);
    check("ovr_level", tx_level, DEPTH_M);
    cyc(0, 0, 0, 0, 1);
    check("ovr_clr", tx_ovr, 0);
    for (int i = 0; i < DEPTH_M; i++) begin
      check("drain_order", tx_data, i);
      cyc(0, 0, 0, 1, 0);
    end
    check("drain_empty", thre, 1);

    // write into full buffer together with a pop
    for (int i = 0; i < DEPTH_M; i++) cyc(1, DW'(8'h20 + i), 0, 0, 0);
    cyc(1, 8'h55, 0, 1, 0);
    check("wp_full_ovr", tx_ovr, 0);
    check("wp_full_level", tx_level, DEPTH_M);
    for (int i = 0; i < DEPTH_M; i++) begin
      e = (i < DEPTH_M - 1) ? DW'(8'h21 + i) : 8'h55;
      check("wp_full_order", tx_data, e);
      cyc(0, 0, 0, 1, 0);
    end

    // wrap-around with interleaved write/pop
    cyc(1, 8'h10, 0, 0, 0);
    for (int i = 1; i < 40; i++) begin
      check("wrap_head", tx_data, 8'h10 + i - 1);
      cyc(1, DW'(8'h10 + i), 0, 1, 0);
      check("wrap_level_le2", tx_level <= 2, 1);
    end
    check("wrap_last", tx_data, 8'h37);
    cyc(0, 0, 0, 1, 0);
    check("wrap_empty", thre, 1);

    // flush keeps overrun; set beats clear
    for (int i = 0; i < DEPTH_M; i++) cyc(1, DW'(8'h40 + i), 0, 0, 0);
    cyc(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < DEPTH_M - L5; i++) cyc(0, 0, 0, 1, 0);
    check("clr_pre_level", tx_level, L5);
    cyc(1, 8'h99, 1, 0, 0);
    check("clr_level", tx_level, 0);
    check("clr_thre", thre, 1);
    check("clr_keeps_ovr", tx_ovr, 1);
    cyc(0, 0, 0, 0, 1);
    check("clr_ovr_cleared", tx_ovr, 0);
    for (int i = 0; i < DEPTH_M; i++) cyc(1, DW'(8'h60 + i), 0, 0, 0);
    cyc(1, 8'h77, 0, 0, 1);
    check("set_beats_clr", tx_ovr, 1);
    cyc(0, 0, 1, 0, 1);

    // asynchronous reset mid-stream
    for (int i = 0; i < L3; i++) cyc(1, DW'(8'h80 + i), 0, 0, 0);
    check("ar_pre_level", tx_level, L3);
    #2 presetn = 1'b0;
    #1;
    check("ar_thre", thre, 1);
    check("ar_level", tx_level, 0);
    check("ar_full", tx_full, 0);
    check("ar_data", tx_data, 0);
    check("ar_ovr", tx_ovr, 0);
    tsr_idle = 1'b0; #1;
    check("ar_temt_lo", temt, 0);
    tsr_idle = 1'b1; #1;
    check("ar_temt_hi", temt, 1);
    @(posedge pclk); #2 presetn = 1'b1;
    @(posedge pclk); #1;

    // randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 1500; n++) begin
      bit wr, clr, ld, oc;
      wr  = ($urandom_range(0, 99) < 55);
      ld  = (exp_q.size() > 0) && ($urandom_range(0, 99) < 40);
      clr = ($urandom_range(0, 99) < 2);
      oc  = ($urandom_range(0, 99) < 6);
      tsr_idle = $urandom_range(0, 1);
      cyc(wr, DW'($urandom_range(0, 255)), clr, ld, oc);
    end

    @(negedge pclk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
